// File: rtl/rv32i_csr_file_pkg.sv
// rv32i_csr_file_pkg
//   Shared definitions for the machine-mode CSR file: CSR addresses, SYSTEM
//   funct3 codes, the decoded read-modify-write operation and the writable
//   mask of mstatus.
//   No ports (package).
package rv32i_csr_file_pkg;

    localparam int CSRAddrBus = 12;

    typedef logic [CSRAddrBus-1:0] csr_addr_t;

    localparam csr_addr_t CSR_MSTATUS   = 12'h300;
    localparam csr_addr_t CSR_MISA      = 12'h301;
    localparam csr_addr_t CSR_MTVEC     = 12'h305;
    localparam csr_addr_t CSR_MSCRATCH  = 12'h340;
    localparam csr_addr_t CSR_MEPC      = 12'h341;
    localparam csr_addr_t CSR_MCAUSE    = 12'h342;
    localparam csr_addr_t CSR_MTVAL     = 12'h343;
    localparam csr_addr_t CSR_MCYCLE    = 12'hB00;
    localparam csr_addr_t CSR_MINSTRET  = 12'hB02;
    localparam csr_addr_t CSR_MCYCLEH   = 12'hB80;
    localparam csr_addr_t CSR_MINSTRETH = 12'hB82;
    localparam csr_addr_t CSR_CYCLE     = 12'hC00;
    localparam csr_addr_t CSR_INSTRET   = 12'hC02;
    localparam csr_addr_t CSR_CYCLEH    = 12'hC80;
    localparam csr_addr_t CSR_INSTRETH  = 12'hC82;

    localparam logic [2:0] CSRRW  = 3'b001;
    localparam logic [2:0] CSRRS  = 3'b010;
    localparam logic [2:0] CSRRC  = 3'b011;
    localparam logic [2:0] CSRRWI = 3'b101;
    localparam logic [2:0] CSRRSI = 3'b110;
    localparam logic [2:0] CSRRCI = 3'b111;

    // Only MIE (bit 3) and MPIE (bit 7) exist in this core's mstatus.
    localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;

    typedef enum logic [1:0] {
        CSR_OP_NONE,
        CSR_OP_RW,
        CSR_OP_RS,
        CSR_OP_RC
    } csr_op_e;

    function automatic csr_op_e csr_decode_op(input logic [2:0] fun3);
        csr_op_e op;
        case (fun3)
            CSRRW, CSRRWI: op = CSR_OP_RW;
            CSRRS, CSRRSI: op = CSR_OP_RS;
            CSRRC, CSRRCI: op = CSR_OP_RC;
            default:       op = CSR_OP_NONE;
        endcase
        return op;
    endfunction

    // Top two address bits 2'b11 mark the architectural read-only space;
    // misa is read-only here as well since it is a constant.
    function automatic logic csr_is_ro(input csr_addr_t addr);
        return (addr[11:10] == 2'b11) || (addr == CSR_MISA);
    endfunction

endpackage

// File: rtl/rv32i_csr_file_counter64.sv
// rv32i_csr_file_counter64 (csr_counter64)
//   64-bit free-running counter with an increment enable and independent
//   32-bit write ports for the low and high halves. A write to either half
//   takes the place of the increment in that cycle: the other half keeps its
//   value and no carry is applied.
// Ports:
//   clk     in   core clock
//   rst     in   synchronous active-low reset
//   inc_en  in   count by one this cycle
//   we_lo   in   replace bits [31:0] with wdata
//   we_hi   in   replace bits [63:32] with wdata
//   wdata   in   32-bit write data
//   count   out  current 64-bit value
module rv32i_csr_file_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_en,
    input  logic        we_lo,
    input  logic        we_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);

    logic [63:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else if (we_lo || we_hi) begin
            if (we_lo) count_q[31:0]  <= wdata;
            if (we_hi) count_q[63:32] <= wdata;
        end else if (inc_en) begin
            count_q <= count_q + 64'd1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/rv32i_csr_file.sv
// rv32i_csr_file
//   Machine-mode CSR responder for the RV32I core. Serves the decode-stage
//   read port combinationally and performs the CSRRW/CSRRS/CSRRC (and
//   immediate) read-modify-write, committing on the next rising clk edge.
//   Optional feature macro CSR_ZICNTR_EN: when defined, the 64-bit
//   mcycle/minstret counters and their read-only shadows exist; when
//   undefined, those addresses are unimplemented and instret_i is ignored.
// Parameters:
//   MTVEC_RESET  reset value of mtvec
//   MISA_VALUE   constant returned by misa
// Ports:
//   clk             in   core clock
//   rst             in   synchronous active-low reset
//   csr_re_i        in   read enable from decode
//   csr_raddr_i     in   CSR read address
//   csr_rdata_o     out  CSR read data (value before any same-cycle write)
//   csr_we_i        in   instruction is a CSR op
//   csr_waddr_i     in   CSR write address
//   csr_fun3_i      in   funct3 of the SYSTEM instruction
//   csr_rs1_i       in   rs1 register data
//   csr_zimm_i      in   zero-extended uimm
//   csr_src_zero_i  in   rs1/uimm field is zero
//   instret_i       in   one instruction retired this cycle
//   csr_illegal_o   out  illegal CSR access this cycle
module rv32i_csr_file
    import rv32i_csr_file_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  csr_re_i,
    input  logic [CSRAddrBus-1:0] csr_raddr_i,
    output logic [31:0]           csr_rdata_o,
    input  logic                  csr_we_i,
    input  logic [CSRAddrBus-1:0] csr_waddr_i,
    input  logic [2:0]            csr_fun3_i,
    input  logic [31:0]           csr_rs1_i,
    input  logic [31:0]           csr_zimm_i,
    input  logic                  csr_src_zero_i,
    input  logic                  instret_i,
    output logic                  csr_illegal_o
);

    logic [31:0] mstatus_q;
    logic [31:0] mtvec_q;
    logic [31:0] mscratch_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] mtval_q;

`ifdef CSR_ZICNTR_EN
    logic [63:0] mcycle_q;
    logic [63:0] minstret_q;
`endif

    function automatic logic csr_implemented(input csr_addr_t addr);
        logic hit;
        case (addr)
            CSR_MSTATUS, CSR_MISA, CSR_MTVEC, CSR_MSCRATCH,
            CSR_MEPC, CSR_MCAUSE, CSR_MTVAL: hit = 1'b1;
`ifdef CSR_ZICNTR_EN
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH,
            CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH: hit = 1'b1;
`endif
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic [31:0] csr_value(input csr_addr_t addr);
        logic [31:0] val;
        case (addr)
            CSR_MSTATUS:  val = mstatus_q;
            CSR_MISA:     val = MISA_VALUE;
            CSR_MTVEC:    val = mtvec_q;
            CSR_MSCRATCH: val = mscratch_q;
            CSR_MEPC:     val = mepc_q;
            CSR_MCAUSE:   val = mcause_q;
            CSR_MTVAL:    val = mtval_q;
`ifdef CSR_ZICNTR_EN
            CSR_MCYCLE,    CSR_CYCLE:    val = mcycle_q[31:0];
            CSR_MCYCLEH,   CSR_CYCLEH:   val = mcycle_q[63:32];
            CSR_MINSTRET,  CSR_INSTRET:  val = minstret_q[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: val = minstret_q[63:32];
`endif
            default:      val = '0;
        endcase
        return val;
    endfunction

    csr_op_e     wr_op;
    logic [31:0] wr_src;
    logic [31:0] wr_old;
    logic [31:0] wr_data;
    logic        wr_eff;
    logic        wr_ro;
    logic        wr_hit;
    logic        rd_hit;
    logic        wr_commit;

    assign wr_op  = csr_decode_op(csr_fun3_i);
    assign wr_src = csr_fun3_i[2] ? csr_zimm_i : csr_rs1_i;
    assign wr_old = csr_value(csr_waddr_i);
    assign wr_ro  = csr_is_ro(csr_waddr_i);
    assign wr_hit = csr_implemented(csr_waddr_i);
    assign rd_hit = csr_implemented(csr_raddr_i);

    // Set/clear with a zero source is a pure read: no write, so no
    // read-only violation either.
    assign wr_eff = csr_we_i &&
                    ((wr_op == CSR_OP_RW) ||
                     (((wr_op == CSR_OP_RS) || (wr_op == CSR_OP_RC)) && !csr_src_zero_i));

    always_comb begin
        wr_data = wr_old;
        case (wr_op)
            CSR_OP_RW: wr_data = wr_src;
            CSR_OP_RS: wr_data = wr_old | wr_src;
            CSR_OP_RC: wr_data = wr_old & ~wr_src;
            default:   wr_data = wr_old;
        endcase
    end

    assign wr_commit = wr_eff && wr_hit && !wr_ro;

    assign csr_illegal_o = (csr_re_i && !rd_hit) ||
                           (csr_we_i && !wr_hit) ||
                           (wr_eff && wr_ro);

    assign csr_rdata_o = csr_re_i ? csr_value(csr_raddr_i) : 32'h0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            mstatus_q  <= '0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else if (wr_commit) begin
            case (csr_waddr_i)
                CSR_MSTATUS:  mstatus_q  <= wr_data & MSTATUS_WMASK;
                CSR_MTVEC:    mtvec_q    <= {wr_data[31:2], 2'b00};
                CSR_MSCRATCH: mscratch_q <= wr_data;
                CSR_MEPC:     mepc_q     <= {wr_data[31:2], 2'b00};
                CSR_MCAUSE:   mcause_q   <= wr_data;
                CSR_MTVAL:    mtval_q    <= wr_data;
                default:      ;
            endcase
        end
    end

`ifdef CSR_ZICNTR_EN
    rv32i_csr_file_counter64 u_mcycle (
        .clk    (clk),
        .rst    (rst),
        .inc_en (1'b1),
        .we_lo  (wr_commit && (csr_waddr_i == CSR_MCYCLE)),
        .we_hi  (wr_commit && (csr_waddr_i == CSR_MCYCLEH)),
        .wdata  (wr_data),
        .count  (mcycle_q)
    );

    rv32i_csr_file_counter64 u_minstret (
        .clk    (clk),
        .rst    (rst),
        .inc_en (instret_i),
        .we_lo  (wr_commit && (csr_waddr_i == CSR_MINSTRET)),
        .we_hi  (wr_commit && (csr_waddr_i == CSR_MINSTRETH)),
        .wdata  (wr_data),
        .count  (minstret_q)
    );
`else
    logic unused_instret;
    assign unused_instret = instret_i;
`endif

endmodule

// File: tb/tb_rv32i_csr_file.sv
// tb_rv32i_csr_file
//   Directed bench for rv32i_csr_file. A reference model (address-keyed
//   register map plus 64-bit counters) advances on every rising edge; one
//   compare process checks rdata/illegal against it on every falling edge.
//   Literal checks in the stimulus pin both DUT and model.
module tb_rv32i_csr_file;

    localparam logic [31:0] TB_MTVEC = 32'h0000_1000;
    localparam logic [31:0] TB_MISA  = 32'h4000_0100;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        re    = 1'b0;
    logic [11:0] raddr = '0;
    logic        we    = 1'b0;
    logic [11:0] waddr = '0;
    logic [2:0]  f3    = '0;
    logic [31:0] rs1   = '0;
    logic [31:0] zimm  = '0;
    logic        srcz  = 1'b0;
    logic        ir    = 1'b0;
    logic [31:0] rdata;
    logic        illegal;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rv32i_csr_file #(
        .MTVEC_RESET (TB_MTVEC),
        .MISA_VALUE  (TB_MISA)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .csr_re_i       (re),
        .csr_raddr_i    (raddr),
        .csr_rdata_o    (rdata),
        .csr_we_i       (we),
        .csr_waddr_i    (waddr),
        .csr_fun3_i     (f3),
        .csr_rs1_i      (rs1),
        .csr_zimm_i     (zimm),
        .csr_src_zero_i (srcz),
        .instret_i      (ir),
        .csr_illegal_o  (illegal)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0]     m_reg  [int];
    logic [31:0]     m_mask [int];
    longint unsigned m_cycle;
    longint unsigned m_instret;
    bit              m_valid = 1'b0;

    function automatic bit m_cnt_addr(input int a);
        return a inside {'hB00, 'hB80, 'hB02, 'hB82, 'hC00, 'hC80, 'hC02, 'hC82};
    endfunction

    function automatic bit m_impl(input int a);
        if (a == 'h301 || m_reg.exists(a)) return 1'b1;
`ifdef CSR_ZICNTR_EN
        return m_cnt_addr(a);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_ro(input int a);
        return (((a >> 10) & 3) == 3) || (a == 'h301);
    endfunction

    function automatic logic [31:0] m_read(input int a);
        if (!m_impl(a)) return 32'h0;
        if (a == 'h301) return TB_MISA;
        if (m_reg.exists(a)) return m_reg[a];
        if (a == 'hB00 || a == 'hC00) return m_cycle[31:0];
        if (a == 'hB80 || a == 'hC80) return m_cycle[63:32];
        if (a == 'hB02 || a == 'hC02) return m_instret[31:0];
        return m_instret[63:32];
    endfunction

    function automatic bit m_eff();
        return we && (f3[1:0] == 2'b01 || (f3[1:0] != 2'b00 && !srcz));
    endfunction

    task automatic m_reset();
        m_reg[32'h300] = 0; m_mask[32'h300] = 32'h0000_0088;
        m_reg[32'h305] = TB_MTVEC; m_mask[32'h305] = 32'hFFFF_FFFC;
        m_reg[32'h340] = 0; m_mask[32'h340] = 32'hFFFF_FFFF;
        m_reg[32'h341] = 0; m_mask[32'h341] = 32'hFFFF_FFFC;
        m_reg[32'h342] = 0; m_mask[32'h342] = 32'hFFFF_FFFF;
        m_reg[32'h343] = 0; m_mask[32'h343] = 32'hFFFF_FFFF;
        m_cycle = 0;
        m_instret = 0;
    endtask

    task automatic m_step();
        int          a;
        logic [31:0] src, old, nv;
        bit          cyc_w, ins_w;
        a = int'(waddr);
        src = f3[2] ? zimm : rs1;
        old = m_read(a);
        case (f3[1:0])
            2'b01:   nv = src;
            2'b10:   nv = old | src;
            default: nv = old & ~src;
        endcase
        cyc_w = 1'b0;
        ins_w = 1'b0;
        if (m_eff() && m_impl(a) && !m_ro(a)) begin
            if (m_reg.exists(a)) m_reg[a] = nv & m_mask[a];
            else if (a == 'hB00) begin m_cycle = {m_cycle[63:32], nv}; cyc_w = 1'b1; end
            else if (a == 'hB80) begin m_cycle = {nv, m_cycle[31:0]}; cyc_w = 1'b1; end
            else if (a == 'hB02) begin m_instret = {m_instret[63:32], nv}; ins_w = 1'b1; end
            else if (a == 'hB82) begin m_instret = {nv, m_instret[31:0]}; ins_w = 1'b1; end
        end
        if (!cyc_w) m_cycle = m_cycle + 1;
        if (!ins_w && ir) m_instret = m_instret + 1;
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            m_reset();
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_step();
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_rdata", rdata, re ? m_read(int'(raddr)) : 32'h0);
            check("model_illegal", {31'b0, illegal},
                  {31'b0, (re && !m_impl(int'(raddr))) || (we && !m_impl(int'(waddr))) ||
                          (m_eff() && m_ro(int'(waddr)))});
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit r, input bit re_v, input logic [11:0] ra, input bit we_v,
                       input logic [11:0] wa, input logic [2:0] f, input logic [31:0] s1,
                       input logic [31:0] zi, input bit sz, input bit ir_v);
        @(posedge clk);
        #1;
        rst = r; re = re_v; raddr = ra; we = we_v; waddr = wa;
        f3 = f; rs1 = s1; zimm = zi; srcz = sz; ir = ir_v;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd(input logic [11:0] a);
        cyc(1, 1, a, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input logic [11:0] a, input logic [2:0] f, input logic [31:0] s1,
                      input logic [31:0] zi, input bit sz);
        cyc(1, 0, 0, 1, a, f, s1, zi, sz, 0);
    endtask

    initial begin
        // reset, with a write request that must be discarded
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 12'h305, 1, 12'h340, 3'b001, 32'h0000_0055, 0, 0, 0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_illegal", {31'b0, illegal}, 32'h0);

        // first cycle out of reset
        rd(12'hB00);
`ifdef CSR_ZICNTR_EN
        check("mcycle_after_rst", rdata, 32'h0);
        check("mcycle_after_rst_ill", {31'b0, illegal}, 32'h0);
`else
        check("b00_unimpl_rdata", rdata, 32'h0);
        check("b00_unimpl_ill", {31'b0, illegal}, 32'h1);
`endif
        rd(12'h305);
        check("mtvec_reset", rdata, TB_MTVEC);
        rd(12'h340);
        check("rst_priority_mscratch", rdata, 32'h0);
        idle();
        idle();
        rd(12'hB00);
`ifdef CSR_ZICNTR_EN
        check("mcycle_plus5", rdata, 32'h5);
`else
        check("b00_unimpl_again", {31'b0, illegal}, 32'h1);
`endif

        // mscratch RW then RCI, read in the request cycle sees old value
        cyc(1, 1, 12'h340, 1, 12'h340, 3'b001, 32'hDEAD_BEEF, 0, 0, 0);
        check("mscratch_same_cycle", rdata, 32'h0);
        cyc(1, 1, 12'h340, 1, 12'h340, 3'b111, 0, 32'h0000_000F, 0, 0);
        check("mscratch_next_cycle", rdata, 32'hDEAD_BEEF);
        rd(12'h340);
        check("mscratch_after_rci", rdata, 32'hDEAD_BEE0);
        check("model_pin_mscratch", m_read('h340), 32'hDEAD_BEE0);

        // mstatus mask
        wr(12'h300, 3'b010, 32'hFFFF_FFFF, 0, 0);
        rd(12'h300);
        check("mstatus_rs_all", rdata, 32'h0000_0088);
        wr(12'h300, 3'b011, 32'h0000_0008, 0, 0);
        rd(12'h300);
        check("mstatus_rc_mie", rdata, 32'h0000_0080);

        // read-only space
        wr(12'hC00, 3'b010, 32'h0, 0, 1);
`ifdef CSR_ZICNTR_EN
        check("cycle_rs_zero_ill", {31'b0, illegal}, 32'h0);
`else
        check("cycle_rs_zero_ill", {31'b0, illegal}, 32'h1);
`endif
        wr(12'hC00, 3'b001, 32'h1, 0, 0);
        check("cycle_rw_ill", {31'b0, illegal}, 32'h1);
        wr(12'h301, 3'b001, 32'h0, 0, 0);
        check("misa_rw_ill", {31'b0, illegal}, 32'h1);
        rd(12'h301);
        check("misa_value", rdata, 32'h4000_0100);
        check("misa_read_ill", {31'b0, illegal}, 32'h0);
        rd(12'h7C0);
        check("unimpl_rdata", rdata, 32'h0);
        check("unimpl_ill", {31'b0, illegal}, 32'h1);
        cyc(1, 0, 12'h305, 0, 0, 0, 0, 0, 0, 0);
        check("re_low_rdata", rdata, 32'h0);

        // alignment masks, immediate forms, no-write funct3
        wr(12'h305, 3'b001, 32'hFFFF_FFFF, 0, 0);
        rd(12'h305);
        check("mtvec_align", rdata, 32'hFFFF_FFFC);
        wr(12'h341, 3'b001, 32'h1234_5677, 0, 0);
        rd(12'h341);
        check("mepc_align", rdata, 32'h1234_5674);
        wr(12'h342, 3'b101, 32'hFFFF_FFFF, 32'h0000_001F, 0);
        rd(12'h342);
        check("mcause_rwi", rdata, 32'h0000_001F);
        wr(12'h343, 3'b001, 32'hA5A5_A5A5, 0, 0);
        wr(12'h343, 3'b111, 0, 0, 1);
        wr(12'h343, 3'b000, 32'h0, 0, 0);
        wr(12'h343, 3'b100, 32'h0, 0, 0);
        rd(12'h343);
        check("mtval_no_write", rdata, 32'hA5A5_A5A5);

`ifdef CSR_ZICNTR_EN
        // counter half writes and carry
        wr(12'hB00, 3'b001, 32'hFFFF_FFFF, 0, 0);
        wr(12'hB80, 3'b001, 32'h0, 0, 0);
        rd(12'hB00);
        check("mcycle_lo_held", rdata, 32'hFFFF_FFFF);
        rd(12'hB80);
        check("mcycleh_carry", rdata, 32'h1);
        rd(12'hC00);
        check("cycle_lo_after_carry", rdata, 32'h1);
        wr(12'hB00, 3'b001, 32'hFFFF_FFFF, 0, 0);
        wr(12'hB80, 3'b001, 32'hFFFF_FFFF, 0, 0);
        rd(12'hC80);
        check("cycleh_all_ones", rdata, 32'hFFFF_FFFF);
        rd(12'hB00);
        check("mcycle_wrap_lo", rdata, 32'h0);
        rd(12'hB80);
        check("mcycle_wrap_hi", rdata, 32'h0);

        // minstret write beats the coincident retire
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 1, 12'hB02, 3'b001, 32'h7, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        rd(12'hB02);
        check("minstret_after_write", rdata, 32'h8);
        rd(12'hC82);
        check("instreth_zero", rdata, 32'h0);
`endif
        idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32i_csr_file.md
Name: rv32i_csr_file

Overview:
- Machine-mode CSR responder for the RV32I core.
- Serves the decode stage's CSR read port (csr_re/csr_raddr) and applies the read-modify-write for CSRRW/CSRRS/CSRRC and their immediate forms.
- Holds the trap CSRs and the 64-bit cycle/instret counters.
- Reads are combinational from state; writes commit on the next rising clk edge.

Parameters:
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec.
- MISA_VALUE, 32'h4000_0100, constant returned by misa (RV32I).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-low reset (ResetEnable = 1'b0), sampled on rising clk
- csr_re_i  in  1  read enable from decode
- csr_raddr_i  in  12  CSR read address
- csr_rdata_o  out  32  CSR read data (old value)
- csr_we_i  in  1  write request (instruction is a CSR op)
- csr_waddr_i  in  12  CSR write address
- csr_fun3_i  in  3  funct3 of the SYSTEM instruction
- csr_rs1_i  in  32  rs1 register data
- csr_zimm_i  in  32  zero-extended uimm[4:0]
- csr_src_zero_i  in  1  rs1 field / uimm field == 0
- instret_i  in  1  one instruction retired this cycle
- csr_illegal_o  out  1  illegal CSR access this cycle (combinational)

Behaviour:
- Reset (rst==0 at a clk edge):
  - mstatus, mscratch, mepc, mcause, mtval, mcycle, minstret ← 0.
  - mtvec ← MTVEC_RESET.
  - Outputs follow state: csr_rdata_o=0 while csr_re_i=0; csr_illegal_o=0.
- Implemented CSRs:
  - misa 0x301: read-only constant.
  - mstatus 0x300: only bits 3 (MIE) and 7 (MPIE) are writable; all others read 0.
  - mtvec 0x305: bits [1:0] are forced to 0.
  - mscratch 0x340, mepc 0x341 (bits [1:0] forced to 0), mcause 0x342, mtval 0x343.
  - mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82.
  - Read-only shadows: cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82.
- Read path:
  - csr_re_i=1: csr_rdata_o = current value at csr_raddr_i, combinational, 0-cycle latency.
  - csr_re_i=0: csr_rdata_o = 0.
  - An unimplemented address reads 0.
- Write operand: src = csr_zimm_i if csr_fun3_i[2]=1, else csr_rs1_i.
- New value by funct3 (old = current value at csr_waddr_i):
  - 001/101 (RW): src.
  - 010/110 (RS): old | src.
  - 011/111 (RC): old & ~src.
  - Any other funct3: no write.
- Write suppression: RS/RC with csr_src_zero_i=1 perform no write and cannot raise illegal-on-write.
- Commit timing: the write commits at the rising edge that ends the request cycle. A read of the same address in the request cycle returns the old value; the read in the next cycle returns the new value.
- Read-only space: csr_waddr_i[11:10]==2'b11, or misa. An effective write there is dropped and asserts csr_illegal_o.
- csr_illegal_o also asserts for any access to an unimplemented address when csr_re_i or csr_we_i is 1.
- Counters:
  - mcycle increments by 1 every cycle out of reset.
  - minstret increments by 1 when instret_i=1.
  - Both are 64-bit and wrap 0xFFFF_FFFF_FFFF_FFFF → 0.
  - A write to the low or high half replaces that half with the written value and suppresses that counter's increment in that cycle. The other half is unchanged; no carry is applied in that cycle.
  - Increment carry from the low half into the high half happens in the same cycle.
- Reset has priority over writes and increments. A write request in the reset cycle is discarded.

Optional Feature:
- Macro: CSR_ZICNTR_EN.
- Defined: the counters and their shadows are implemented as described above.
- Undefined:
  - No counter flops are instantiated.
  - Addresses 0xB00/0xB80/0xB02/0xB82/0xC00/0xC80/0xC02/0xC82 are treated as unimplemented: they read 0 and assert csr_illegal_o.
  - instret_i is ignored.

Decomposition:
- Shared defines file holds:
  - CSR address constants (CSR_MSTATUS … CSR_INSTRETH).
  - CSR funct3 codes (CSRRW/CSRRS/CSRRC/CSRRWI/CSRRSI/CSRRCI).
  - CSRAddrBus.
  - mstatus writable mask.
- One natural sub-module: csr_counter64.
  - 64-bit counter with increment enable.
  - Independent low/high write enables.
  - Write-suppresses-increment rule.
  - Instantiated twice, under CSR_ZICNTR_EN.

Test Plan:
- Reset, then read mtvec at 0x305 → csr_rdata_o=MTVEC_RESET. Read mcycle the cycle after reset release → 0; 5 cycles later → 5.
- CSRRW mscratch, rs1=0xDEAD_BEEF → read in the same cycle returns 0; the next cycle returns 0xDEAD_BEEF. Then CSRRCI with zimm=0xF → 0xDEAD_BEE0.
- CSRRS mstatus, rs1=0xFFFF_FFFF → reads back 0x0000_0088. CSRRS with csr_src_zero_i=1 on 0xC00 → no write, csr_illegal_o=0.
- CSRRW cycle at 0xC00 with rs1=1 → csr_illegal_o=1, cycle is unchanged. Read at 0x7C0 → rdata=0, illegal=1.
- Write mcycle=0xFFFF_FFFF, then mcycleh=0 on the next cycle.
  - The mcycleh write suppresses the increment, so the following cycle reads mcycle=0xFFFF_FFFF, mcycleh=0.
  - One cycle later: mcycle=0, mcycleh=1 (carry).
  - Pulse instret_i 3 times with a write to minstret=7 coincident with the 2nd pulse → minstret=8 afterwards.
- With CSR_ZICNTR_EN undefined, read 0xB00 → rdata=0, csr_illegal_o=1.
